// File: rtl/sga_move_control_if.sv
// rtl/sga_move_control_if.sv - control/status bundle of the snake move controller
// Ports carried:
//   buttons[3:0]   raw active-high direction buttons (bit i requests direction i)
//   enable         playing state from UC; timer runs only when 1
//   pause          freezes the step timer
//   clear          synchronous game clear
//   size[3:0]      current snake size from FD
//   direction[1:0] committed direction (00 up, 01 right, 10 down, 11 left)
//   end_play_time  one-cycle step tick
//   dir_changed    one-cycle pulse when a tick commits a new direction
//   db_pending[1:0] pending direction (debug)
// Modports: master drives the inputs (UC/board side), slave is the controller.
interface sga_move_control_if;
   logic [3:0] buttons;
   logic       enable;
   logic       pause;
   logic       clear;
   logic [3:0] size;
   logic [1:0] direction;
   logic       end_play_time;
   logic       dir_changed;
   logic [1:0] db_pending;

   modport master (
      output buttons, enable, pause, clear, size,
      input  direction, end_play_time, dir_changed, db_pending
   );

   modport slave (
      input  buttons, enable, pause, clear, size,
      output direction, end_play_time, dir_changed, db_pending
   );
endinterface

// File: rtl/sga_move_control.sv
// rtl/sga_move_control.sv - button debounce, direction arbitration and step timer
// Ports:
//   clock      sole clock, rising edge
//   restart_n  asynchronous active-low reset
//   bus        sga_move_control_if.slave (buttons/enable/pause/clear/size in,
//              direction/end_play_time/dir_changed/db_pending out)
// Optional feature: define SGA_SPEEDUP_EN to shorten the step period with snake
// size, period = max(MOVE_PERIOD - size*SPEEDUP_STEP, MIN_PERIOD).
module sga_move_control #(
   parameter int DEBOUNCE_CYCLES = 1000,
   parameter int MOVE_PERIOD     = 25000000,
   parameter int SPEEDUP_STEP    = 1000000,
   parameter int MIN_PERIOD      = 5000000
) (
   input logic               clock,
   input logic               restart_n,
   sga_move_control_if.slave bus
);

   localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);

   logic [3:0]     sync1, sync2;
   logic [3:0]     accepted, accepted_d;
   logic [DBW-1:0] db_cnt [4];

   logic [1:0]  direction, pending;
   logic [31:0] count;
   logic        end_play_time, dir_changed;

   logic [3:0]  press;
   logic        press_valid;
   logic [1:0]  press_dir;
   logic [1:0]  ref_dir;
   logic [31:0] eff_period;
   logic        running, tick;

   // Synchronizer and per-bit debounce; untouched by clear.
   always_ff @(posedge clock or negedge restart_n) begin
      if (!restart_n) begin
         sync1      <= '0;
         sync2      <= '0;
         accepted   <= '0;
         accepted_d <= '0;
         for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
      end else begin
         sync1      <= bus.buttons;
         sync2      <= sync1;
         accepted_d <= accepted;
         for (int i = 0; i < 4; i++) begin
            if (sync2[i] == accepted[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
               // this cycle is the DEBOUNCE_CYCLES-th consecutive difference
               accepted[i] <= sync2[i];
               db_cnt[i]   <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign press = accepted & ~accepted_d;

   // Lowest bit index wins when several presses land in one cycle.
   always_comb begin
      press_valid = |press;
      press_dir   = 2'd0;
      if (press[0])      press_dir = 2'd0;
      else if (press[1]) press_dir = 2'd1;
      else if (press[2]) press_dir = 2'd2;
      else if (press[3]) press_dir = 2'd3;
   end

`ifdef SGA_SPEEDUP_EN
   logic [31:0] period_q;
   logic [31:0] period_calc;
   logic [63:0] dec;

   // Wide arithmetic so a large size cannot underflow the subtraction.
   always_comb begin
      dec = 64'(bus.size) * 64'(SPEEDUP_STEP);
      if (dec + 64'(MIN_PERIOD) >= 64'(MOVE_PERIOD)) period_calc = 32'(MIN_PERIOD);
      else                                           period_calc = 32'(64'(MOVE_PERIOD) - dec);
   end

   // Period is latched at count 0 so a size change never stretches a running step.
   always_ff @(posedge clock or negedge restart_n) begin
      if (!restart_n)       period_q <= 32'(MOVE_PERIOD);
      else if (count == 0)  period_q <= period_calc;
   end

   assign eff_period = (count == 0) ? period_calc : period_q;
`else
   logic unused_size;
   assign unused_size = ^bus.size;
   assign eff_period  = 32'(MOVE_PERIOD);
`endif

   assign running = bus.enable && !bus.pause;
   assign tick    = running && (count == eff_period - 32'd1);
   // Reversal is judged against the value being committed in a tick cycle.
   assign ref_dir = tick ? pending : direction;

   always_ff @(posedge clock or negedge restart_n) begin
      if (!restart_n) begin
         direction     <= 2'b01;
         pending       <= 2'b01;
         count         <= '0;
         end_play_time <= 1'b0;
         dir_changed   <= 1'b0;
      end else if (bus.clear) begin
         direction     <= 2'b01;
         pending       <= 2'b01;
         count         <= '0;
         end_play_time <= 1'b0;
         dir_changed   <= 1'b0;
      end else begin
         end_play_time <= 1'b0;
         dir_changed   <= 1'b0;
         if (!bus.enable) begin
            count <= '0;
         end else if (!bus.pause) begin
            if (tick) begin
               count         <= '0;
               end_play_time <= 1'b1;
               direction     <= pending;
               dir_changed   <= (pending != direction);
            end else begin
               count <= count + 32'd1;
            end
         end
         if (press_valid && (press_dir != (ref_dir ^ 2'b10)))
            pending <= press_dir;
      end
   end

   assign bus.direction     = direction;
   assign bus.db_pending    = pending;
   assign bus.end_play_time = end_play_time;
   assign bus.dir_changed   = dir_changed;

endmodule

// File: doc/sga_move_control.md
SGA_MOVE_CONTROL -- requirements
Module: sga_move_control

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000: consecutive stable cycles before a button level is accepted.
REQ-002 Parameter MOVE_PERIOD, default 25000000: clock cycles per snake step.
REQ-003 Parameter SPEEDUP_STEP, default 1000000: cycles removed from the period per size unit (SGA_SPEEDUP_EN only).
REQ-004 Parameter MIN_PERIOD, default 5000000: lower bound on the effective period (SGA_SPEEDUP_EN only).
REQ-005 clock  in  1  sole clock; all state updates on its rising edge.
REQ-006 restart_n  in  1  asynchronous, active-low reset.
REQ-007 buttons  in  4  raw asynchronous buttons, active-high; bit i requests direction i.
REQ-008 enable  in  1  UC is in a playing state; timer runs only when 1.
REQ-009 pause  in  1  freezes the timer while 1.
REQ-010 clear  in  1  synchronous game clear from UC.
REQ-011 size  in  4  current snake size from FD.
REQ-012 direction  out  2  committed direction: 00 up, 01 right, 10 down, 11 left.
REQ-013 end_play_time  out  1  one-cycle step tick to UC.
REQ-014 dir_changed  out  1  one-cycle pulse when a tick commits a different direction.
REQ-015 db_pending  out  2  pending direction, for debug.

Function
REQ-016 Each button bit is passed through a 2-flop synchronizer before any other logic.
REQ-017 Per bit: the counter clears when the synchronized level equals the accepted level; otherwise it increments, and the level is accepted when the count reaches DEBOUNCE_CYCLES.
REQ-018 A press event is a one-cycle pulse on each 0->1 transition of an accepted level; releases generate no event.
REQ-019 Multiple press events in one cycle: the lowest bit index wins and the others are discarded.
REQ-020 A press for direction d loads pending with d unless d equals the reference direction XOR 2'b10 (reversal); a reversal press is dropped.
REQ-021 The reference direction is direction, except in a tick cycle, where it is the value being committed.
REQ-022 Later accepted presses overwrite earlier ones; the last press before a tick wins.
REQ-023 Timer: while enable=1 and pause=0, count increments each cycle; at count = period-1, end_play_time=1 for that cycle, count wraps to 0, and direction<=pending.
REQ-024 pause=1 holds count and suppresses ticks; press handling continues.
REQ-025 enable=0 forces count to 0 with no ticks; direction and pending are held.
REQ-026 dir_changed=1 in the tick cycle iff the committed value differs from the prior direction.
REQ-027 clear=1 (priority over all other events in the cycle): direction=01, pending=01, count=0, end_play_time=0, dir_changed=0; debounce state is untouched.
REQ-028 First tick after enable rises occurs exactly period cycles later.

Reset
REQ-029 restart_n=0 asynchronously sets: direction=01, db_pending=01, end_play_time=0, dir_changed=0, count=0, all debounce counters=0, accepted levels=0, synchronizers=0.
REQ-030 Release of restart_n mid-press: the press requires a full DEBOUNCE_CYCLES from the synchronized input before it is recognized.

Configuration
REQ-031 Macro SGA_SPEEDUP_EN defined: period = max(MOVE_PERIOD - size*SPEEDUP_STEP, MIN_PERIOD), computed without underflow and sampled only when count=0.
REQ-032 Macro SGA_SPEEDUP_EN undefined: period = MOVE_PERIOD; size, SPEEDUP_STEP and MIN_PERIOD are ignored.

Verification (DEBOUNCE_CYCLES=3, MOVE_PERIOD=10, SPEEDUP_STEP=2, MIN_PERIOD=4)
REQ-033 Reset release, enable=1, no buttons: end_play_time pulses every 10 cycles; direction stays 01; dir_changed stays 0.
REQ-034 buttons[2] high for 2 cycles -> ignored; buttons[0] held 6 cycles -> db_pending=00, then next tick gives direction=00 with dir_changed=1.
REQ-035 direction=01, press buttons[3] (left) -> db_pending stays 01; next tick, direction=01, dir_changed=0.
REQ-036 buttons[0] and buttons[2] accepted in the same cycle -> db_pending=00; pause=1 for 20 cycles -> no ticks and count frozen, resumes on release.
REQ-037 clear asserted in a tick cycle -> end_play_time=0, direction=01, count=0; with SGA_SPEEDUP_EN and size=2, tick spacing is 6; with size=5, spacing is 4.
